// File: rtl/burst_master_port.sv
// burst_master_port: serial bus master that requests the bus, shifts out a
// slave/address/burst-count header, then moves a multi-beat write or read
// burst one serial beat at a time. Stalls and grant loss abort with an error
// pulse so the bus is never held indefinitely.
module burst_master_port #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 write,
    input  logic [ADDR_LEN-1:0]  address,
    input  logic [SLAVE_LEN-1:0] slave_select,
    input  logic [BURST_LEN-1:0] burst_num,
    input  logic [DATA_LEN-1:0]  wr_data,
    output logic                 wr_data_req,
    input  logic                 approval_grant,
    input  logic                 busy,
    input  logic                 slave_ready,
    input  logic                 slave_valid,
    input  logic                 rx_data,
    output logic                 approval_request,
    output logic                 tx_slave_select,
    output logic                 tx_address,
    output logic                 tx_burst_number,
    output logic                 tx_data,
    output logic                 master_valid,
    output logic                 write_en,
    output logic                 read_en,
    output logic [DATA_LEN-1:0]  rd_data,
    output logic                 new_rx,
    output logic                 tx_done,
    output logic                 error
);

    // Header length is the longest of the three serial fields.
    localparam int HDR_LEN = (SLAVE_LEN > ADDR_LEN)
                             ? ((SLAVE_LEN > BURST_LEN) ? SLAVE_LEN : BURST_LEN)
                             : ((ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN);
    localparam int HW = $clog2(HDR_LEN + 1);
    localparam int DW = $clog2(DATA_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [HW-1:0] HDR_LAST = HW'(HDR_LEN - 1);
    localparam logic [DW-1:0] BIT_LAST = DW'(DATA_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REQ      = 4'd1;
    localparam logic [3:0] S_HDR      = 4'd2;
    localparam logic [3:0] S_WAIT_RDY = 4'd3;
    localparam logic [3:0] S_LOAD     = 4'd4;
    localparam logic [3:0] S_WR_SHIFT = 4'd5;
    localparam logic [3:0] S_RD_SHIFT = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_ABORT    = 4'd8;

    logic [3:0]           state_r,   state_s;
    logic                 write_r,   write_s;
    logic [SLAVE_LEN-1:0] ss_sh_r,   ss_sh_s;
    logic [ADDR_LEN-1:0]  addr_sh_r, addr_sh_s;
    logic [BURST_LEN-1:0] bn_sh_r,   bn_sh_s;
    logic [DATA_LEN-1:0]  wr_sh_r,   wr_sh_s;
    logic [DATA_LEN-1:0]  rx_sh_r,   rx_sh_s;
    logic [BURST_LEN-1:0] beats_r,   beats_s;
    logic [HW-1:0]        hdr_cnt_r, hdr_cnt_s;
    logic [DW-1:0]        bit_cnt_r, bit_cnt_s;
    logic [TW-1:0]        to_cnt_r,  to_cnt_s;
    logic                 rd_load_s;
    logic                 on_bus_s;
    logic                 typed_s;

    // Next-state and datapath update for the transaction sequencer.
    always_comb begin
        state_s   = state_r;
        write_s   = write_r;
        ss_sh_s   = ss_sh_r;
        addr_sh_s = addr_sh_r;
        bn_sh_s   = bn_sh_r;
        wr_sh_s   = wr_sh_r;
        rx_sh_s   = rx_sh_r;
        beats_s   = beats_r;
        hdr_cnt_s = hdr_cnt_r;
        bit_cnt_s = bit_cnt_r;
        to_cnt_s  = to_cnt_r;
        rd_load_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s   = S_REQ;
                    write_s   = write;
                    ss_sh_s   = slave_select;
                    addr_sh_s = address;
                    bn_sh_s   = burst_num;
                    beats_s   = (burst_num == BURST_LEN'(0)) ? BURST_LEN'(1) : burst_num;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (approval_grant && !busy) begin
                    state_s   = S_HDR;
                    hdr_cnt_s = HW'(0);
                end else begin
                    state_s = S_REQ;
                end
            end
            S_HDR: begin
                if (!approval_grant) begin
                    state_s = S_ABORT;
                end else begin
                    // Shifting right feeds zeros once a short field runs out.
                    ss_sh_s   = ss_sh_r >> 1;
                    addr_sh_s = addr_sh_r >> 1;
                    bn_sh_s   = bn_sh_r >> 1;
                    if (hdr_cnt_r == HDR_LAST) begin
                        state_s   = write_r ? S_WAIT_RDY : S_RD_SHIFT;
                        bit_cnt_s = DW'(0);
                    end else begin
                        hdr_cnt_s = hdr_cnt_r + HW'(1);
                    end
                end
            end
            S_WAIT_RDY: begin
                if (!approval_grant) begin
                    state_s = S_ABORT;
                end else if (slave_ready) begin
                    state_s = S_LOAD;
                end else if (to_cnt_r == TO_LAST) begin
                    state_s = S_ABORT;
                end else begin
                    to_cnt_s = to_cnt_r + TW'(1);
                end
            end
            S_LOAD: begin
                if (!approval_grant) begin
                    state_s = S_ABORT;
                end else begin
                    state_s   = S_WR_SHIFT;
                    wr_sh_s   = wr_data;
                    bit_cnt_s = DW'(0);
                end
            end
            S_WR_SHIFT: begin
                if (!approval_grant) begin
                    state_s = S_ABORT;
                end else begin
                    wr_sh_s = wr_sh_r >> 1;
                    if (bit_cnt_r == BIT_LAST) begin
                        beats_s = beats_r - BURST_LEN'(1);
                        state_s = (beats_r == BURST_LEN'(1)) ? S_DONE : S_WAIT_RDY;
                    end else begin
                        bit_cnt_s = bit_cnt_r + DW'(1);
                    end
                end
            end
            S_RD_SHIFT: begin
                if (!approval_grant) begin
                    state_s = S_ABORT;
                end else if (slave_valid) begin
                    // New bit enters at the MSB so the first bit ends at the LSB.
                    rx_sh_s  = (rx_sh_r >> 1) | (DATA_LEN'(rx_data) << (DATA_LEN - 1));
                    to_cnt_s = TW'(0);
                    if (bit_cnt_r == BIT_LAST) begin
                        rd_load_s = 1'b1;
                        bit_cnt_s = DW'(0);
                        beats_s   = beats_r - BURST_LEN'(1);
                        state_s   = (beats_r == BURST_LEN'(1)) ? S_DONE : S_RD_SHIFT;
                    end else begin
                        bit_cnt_s = bit_cnt_r + DW'(1);
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    state_s = S_ABORT;
                end else begin
                    to_cnt_s = to_cnt_r + TW'(1);
                end
            end
            S_DONE:  state_s = S_IDLE;
            S_ABORT: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
        // Every stall budget starts afresh in a new state.
        if (state_s != state_r) begin
            to_cnt_s = TW'(0);
        end else begin
            to_cnt_s = to_cnt_s;
        end
    end

    // Output qualifiers derived from the upcoming state.
    always_comb begin
        on_bus_s = (state_s == S_REQ) || (state_s == S_HDR) || (state_s == S_WAIT_RDY) ||
                   (state_s == S_LOAD) || (state_s == S_WR_SHIFT) || (state_s == S_RD_SHIFT);
        typed_s  = on_bus_s && (state_s != S_REQ) ||
                   (state_s == S_DONE) || (state_s == S_ABORT);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= S_IDLE;
            write_r          <= 1'b0;
            ss_sh_r          <= SLAVE_LEN'(0);
            addr_sh_r        <= ADDR_LEN'(0);
            bn_sh_r          <= BURST_LEN'(0);
            wr_sh_r          <= DATA_LEN'(0);
            rx_sh_r          <= DATA_LEN'(0);
            beats_r          <= BURST_LEN'(0);
            hdr_cnt_r        <= HW'(0);
            bit_cnt_r        <= DW'(0);
            to_cnt_r         <= TW'(0);
            approval_request <= 1'b0;
            master_valid     <= 1'b0;
            tx_slave_select  <= 1'b0;
            tx_address       <= 1'b0;
            tx_burst_number  <= 1'b0;
            tx_data          <= 1'b0;
            wr_data_req      <= 1'b0;
            write_en         <= 1'b0;
            read_en          <= 1'b0;
            rd_data          <= DATA_LEN'(0);
            new_rx           <= 1'b0;
            tx_done          <= 1'b0;
            error            <= 1'b0;
        end else begin
            state_r          <= state_s;
            write_r          <= write_s;
            ss_sh_r          <= ss_sh_s;
            addr_sh_r        <= addr_sh_s;
            bn_sh_r          <= bn_sh_s;
            wr_sh_r          <= wr_sh_s;
            rx_sh_r          <= rx_sh_s;
            beats_r          <= beats_s;
            hdr_cnt_r        <= hdr_cnt_s;
            bit_cnt_r        <= bit_cnt_s;
            to_cnt_r         <= to_cnt_s;
            approval_request <= on_bus_s;
            master_valid     <= (state_s == S_HDR) || (state_s == S_WR_SHIFT);
            tx_slave_select  <= (state_s == S_HDR) && ss_sh_s[0];
            tx_address       <= (state_s == S_HDR) && addr_sh_s[0];
            tx_burst_number  <= (state_s == S_HDR) && bn_sh_s[0];
            tx_data          <= (state_s == S_WR_SHIFT) && wr_sh_s[0];
            wr_data_req      <= (state_s == S_LOAD);
            write_en         <= typed_s && write_s;
            read_en          <= typed_s && !write_s;
            if (rd_load_s) begin
                rd_data <= rx_sh_s;
            end else begin
                rd_data <= rd_data;
            end
            new_rx           <= rd_load_s;
            tx_done          <= (state_s == S_DONE);
            error            <= (state_s == S_ABORT);
        end
    end

endmodule

// File: tb/tb_burst_master_port.sv
// Self-checking bench for burst_master_port: a procedural transaction model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_burst_master_port;
    localparam int SL = 2, AL = 12, DL = 8, BL = 12, TO = 255, H = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, start = 1'b0, write = 1'b0;
    logic [AL-1:0] address = '0;
    logic [SL-1:0] slave_select = '0;
    logic [BL-1:0] burst_num = '0;
    logic [DL-1:0] wr_data = '0;
    logic approval_grant = 1'b0, busy = 1'b0, slave_ready = 1'b0;
    logic slave_valid = 1'b0, rx_data = 1'b0;
    logic wr_data_req, approval_request, tx_slave_select, tx_address;
    logic tx_burst_number, tx_data, master_valid, write_en, read_en;
    logic [DL-1:0] rd_data;
    logic new_rx, tx_done, error;

    burst_master_port #(.SLAVE_LEN(SL), .ADDR_LEN(AL), .DATA_LEN(DL),
                        .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .write(write),
        .address(address), .slave_select(slave_select), .burst_num(burst_num),
        .wr_data(wr_data), .wr_data_req(wr_data_req),
        .approval_grant(approval_grant), .busy(busy), .slave_ready(slave_ready),
        .slave_valid(slave_valid), .rx_data(rx_data),
        .approval_request(approval_request), .tx_slave_select(tx_slave_select),
        .tx_address(tx_address), .tx_burst_number(tx_burst_number),
        .tx_data(tx_data), .master_valid(master_valid), .write_en(write_en),
        .read_en(read_en), .rd_data(rd_data), .new_rx(new_rx),
        .tx_done(tx_done), .error(error));

    int n_chk = 0, n_pass = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit e_req, e_mv, e_ss, e_ad, e_bn, e_td, e_wreq, e_wen, e_ren, e_newrx, e_done, e_err;
    logic [DL-1:0] e_rd = '0;

    // advance one edge; outputs for the following cycle start from quiet lines
    task automatic nxt(output bit r);
        @(posedge clk);
        r = reset;
        {e_mv, e_ss, e_ad, e_bn, e_td, e_wreq, e_newrx, e_done, e_err} = '0;
        if (r) begin
            {e_req, e_wen, e_ren} = '0;
            e_rd = '0;
        end
    endtask

    // 0 = continue, 1 = reset seen, 2 = grant lost
    task automatic step(output int st);
        bit r;
        nxt(r);
        if (r) st = 1;
        else if (!approval_grant) st = 2;
        else st = 0;
    endtask

    initial begin : model_p
        bit r;
        int st, beats, stall, k;
        logic w;
        logic [AL-1:0] a;
        logic [SL-1:0] s;
        logic [BL-1:0] b;
        logic [DL-1:0] d, val;
        {e_req, e_mv, e_ss, e_ad, e_bn, e_td, e_wreq, e_wen, e_ren, e_newrx, e_done, e_err} = '0;
        forever begin
            nxt(r);
            if (r || !start) continue;
            w = write; a = address; s = slave_select; b = burst_num;
            beats = (b == 0) ? 1 : int'(b);
            e_req = 1'b1;
            do nxt(r); while (!r && !(approval_grant && !busy));
            if (r) continue;
            st = 0;
            e_wen = w; e_ren = !w;
            for (int h = 0; h < H && st == 0; h++) begin
                e_mv = 1'b1;
                e_ss = (h < SL) ? s[h] : 1'b0;
                e_ad = (h < AL) ? a[h] : 1'b0;
                e_bn = (h < BL) ? b[h] : 1'b0;
                step(st);
            end
            if (w) begin
                while (st == 0 && beats > 0) begin
                    stall = 0;
                    forever begin
                        step(st);
                        if (st != 0 || slave_ready) break;
                        stall++;
                        if (stall == TO) begin st = 2; break; end
                    end
                    if (st != 0) break;
                    e_wreq = 1'b1;
                    step(st);
                    if (st != 0) break;
                    d = wr_data;
                    for (int i = 0; i < DL && st == 0; i++) begin
                        e_mv = 1'b1; e_td = d[i];
                        step(st);
                    end
                    if (st == 0) beats--;
                end
            end else begin
                k = 0; stall = 0; val = '0;
                while (st == 0 && beats > 0) begin
                    step(st);
                    if (st != 0) break;
                    if (slave_valid) begin
                        val[k] = rx_data; k++; stall = 0;
                        if (k == DL) begin
                            e_rd = val; e_newrx = 1'b1; beats--; k = 0;
                        end
                    end else begin
                        stall++;
                        if (stall == TO) st = 2;
                    end
                end
            end
            if (st == 1) continue;
            if (st == 2) e_err = 1'b1; else e_done = 1'b1;
            e_req = 1'b0;
            nxt(r);
            if (!r) begin e_wen = 1'b0; e_ren = 1'b0; end
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_on)
            chk("outputs",
                {approval_request, master_valid, tx_slave_select, tx_address, tx_burst_number,
                 tx_data, wr_data_req, write_en, read_en, new_rx, tx_done, error, rd_data},
                {e_req, e_mv, e_ss, e_ad, e_bn, e_td, e_wreq, e_wen, e_ren, e_newrx,
                 e_done, e_err, e_rd});
    end

    // ---------------- monitor / write-data source ----------------
    int cyc = 0, mv_n = 0, wreq_n = 0, newrx_n = 0, done_n = 0, err_n = 0, wi = 0;
    int mv_first = 0, last_mv = 0, err_t = 0;
    int wreq_t[8];
    logic [DL-1:0] rd_hist[4];
    logic [AL-1:0] addr_col;
    logic [SL-1:0] ss_col;
    logic [BL-1:0] bn_col;
    logic [DL-1:0] dat_col;
    logic [DL-1:0] wq[4];

    always @(negedge clk) begin
        cyc++;
        if (start) begin
            mv_n = 0; wreq_n = 0; newrx_n = 0; done_n = 0; err_n = 0; wi = 0;
        end
        if (master_valid) begin
            if (mv_n == 0) mv_first = cyc;
            if (mv_n < AL) addr_col[mv_n] = tx_address;
            if (mv_n < SL) ss_col[mv_n] = tx_slave_select;
            if (mv_n < BL) bn_col[mv_n] = tx_burst_number;
            if (mv_n >= H && mv_n < H + DL) dat_col[mv_n - H] = tx_data;
            mv_n++;
            last_mv = cyc;
        end
        if (wr_data_req) begin
            if (wreq_n < 8) wreq_t[wreq_n] = cyc;
            wreq_n++;
            wr_data = wq[wi % 4];
            wi++;
        end
        if (new_rx) begin
            if (newrx_n < 4) rd_hist[newrx_n] = rd_data;
            newrx_n++;
        end
        if (tx_done) done_n++;
        if (error) begin err_n++; err_t = cyc; end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go(input logic w, input logic [AL-1:0] a, input logic [SL-1:0] s,
                      input logic [BL-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; write = w; address = a; slave_select = s; burst_num = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_n + err_n > 0) begin ok = 1'b1; break; end
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic wait_wreq(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (wreq_n >= n) begin ok = 1'b1; break; end
        end
        chk("wreq_wait", ok, 1'b1);
    endtask

    task automatic drive_rx(input logic [DL-1:0] b0, input logic [DL-1:0] b1,
                            input logic [DL-1:0] b2, input int nb);
        logic [DL-1:0] by[3];
        bit seen = 1'b0;
        by[0] = b0; by[1] = b1; by[2] = b2;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (master_valid) seen = 1'b1;
            else if (seen) break;
        end
        for (int bb = 0; bb < nb; bb++) begin
            for (int i = 0; i < DL; i++) begin
                if (i % 3 == 1) begin slave_valid = 1'b0; @(negedge clk); end
                slave_valid = 1'b1; rx_data = by[bb][i];
                @(negedge clk);
            end
        end
        slave_valid = 1'b0; rx_data = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : main_p
        int t_b;
        @(posedge clk); #1;
        cmp_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_req", approval_request, 1'b0);
        chk("reset_rd", rd_data, 8'h00);

        // single write beat, grant after 3 cycles
        slave_ready = 1'b1;
        wq[0] = 8'h3C;
        go(1'b1, 12'hA5C, 2'd2, 12'd1);
        repeat (2) @(posedge clk);
        #1 approval_grant = 1'b1;
        wait_end("t1_end", 100);
        chk("t1_addr", addr_col, 12'hA5C);
        chk("t1_ss", ss_col, 2'b10);
        chk("t1_bn", bn_col, 12'd1);
        chk("t1_data", dat_col, 8'h3C);
        chk("t1_mv_cycles", mv_n, 20);
        chk("t1_wreq", wreq_n, 1);
        chk("t1_done", done_n, 1);
        chk("t1_err", err_n, 0);

        // burst of 4 with a 5-cycle slave_ready stall before beat 3
        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44;
        go(1'b1, 12'h123, 2'd1, 12'd4);
        wait_wreq(2);
        slave_ready = 1'b0;
        repeat (14) @(negedge clk);
        slave_ready = 1'b1;
        wait_end("t2_end", 200);
        chk("t2_wreq", wreq_n, 4);
        chk("t2_gap_normal", wreq_t[1] - wreq_t[0], DL + 2);
        chk("t2_gap_stall", wreq_t[2] - wreq_t[1], DL + 2 + 5);
        chk("t2_done", done_n, 1);
        chk("t2_err", err_n, 0);

        // read burst of 3 with valid gaps
        go(1'b0, 12'h0F0, 2'd3, 12'd3);
        drive_rx(8'h81, 8'h00, 8'hFF, 3);
        wait_end("t3_end", 200);
        chk("t3_newrx", newrx_n, 3);
        chk("t3_rd0", rd_hist[0], 8'h81);
        chk("t3_rd1", rd_hist[1], 8'h00);
        chk("t3_rd2", rd_hist[2], 8'hFF);
        chk("t3_done", done_n, 1);

        // read timeout with slave_valid stuck low
        go(1'b0, 12'h555, 2'd0, 12'd1);
        wait_end("t4_end", 400);
        chk("t4_err", err_n, 1);
        chk("t4_done", done_n, 0);
        chk("t4_latency", err_t - last_mv, TO + 1);
        @(negedge clk);
        chk("t4_req_drop", approval_request, 1'b0);
        chk("t4_rd_kept", rd_data, 8'hFF);

        // grant dropped during beat 2, then a clean transaction
        wq[0] = 8'hAA; wq[1] = 8'h55; wq[2] = 8'hC3;
        go(1'b1, 12'h777, 2'd2, 12'd3);
        wait_wreq(2);
        repeat (3) @(negedge clk);
        approval_grant = 1'b0;
        wait_end("t5_end", 100);
        chk("t5_err", err_n, 1);
        chk("t5_done", done_n, 0);
        approval_grant = 1'b1;
        wq[0] = 8'h96;
        go(1'b1, 12'h001, 2'd1, 12'd0);
        wait_end("t5b_end", 100);
        chk("t5b_done", done_n, 1);
        chk("t5b_err", err_n, 0);

        // reset mid-header
        go(1'b1, 12'hFFF, 2'd3, 12'd2);
        for (int g = 0; g < 50 && !master_valid; g++) @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", approval_request, 1'b0);
        chk("t6_rst_mv", master_valid, 1'b0);
        chk("t6_rst_wen", write_en, 1'b0);
        reset = 1'b0;

        // start while busy: request holds, header one cycle after busy falls
        busy = 1'b1;
        go(1'b0, 12'h3A5, 2'd1, 12'd1);
        repeat (4) @(negedge clk);
        chk("t6_req_held", approval_request, 1'b1);
        busy = 1'b0;
        #1 t_b = cyc;
        drive_rx(8'h5A, 8'h00, 8'h00, 1);
        wait_end("t6_end", 100);
        chk("t6_hdr_start", mv_first, t_b + 1);
        chk("t6_rd", rd_hist[0], 8'h5A);
        chk("t6_done", done_n, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
